// File: rtl/avst_rr_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the Avalon-ST arbiter.
package avst_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam int MAX_SRC = 32;
  localparam int IDX_W   = 5;

  // Returns a one-hot grant: first set bit of req searching last+1, last+2, ... mod n.
  function automatic logic [MAX_SRC-1:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                                 input logic [IDX_W-1:0]   last,
                                                 input int                 n);
    logic [MAX_SRC-1:0] pick;
    logic               found;
    logic [IDX_W-1:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_SRC; i++) begin
      idx = IDX_W'((int'(last) + i) % n);
      if (i <= n && !found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/avst_rr_arbiter_skid2.sv
// Two-entry skid FIFO on the arbiter output; head entry is always presented on dout.
module avst_skid2 #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            cnt
);

  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic                  do_push;
  logic                  do_pop;

  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && ((cnt != 2'd2) || do_pop);
  assign dout    = head;

  // Entry storage and occupancy; simultaneous push/pop keeps the count and the order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            head <= din;
          end else begin
            tail <= din;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/avst_rr_arbiter.sv
// N-source to 1-sink round-robin Avalon-ST arbiter with burst-limited grants
// and a 2-entry output skid buffer.
module avst_rr_arbiter
  import avst_arb_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 512,
  parameter int MAX_BURST  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_SRC-1:0]            i_src_vld,
  input  logic [N_SRC*DATA_WIDTH-1:0] i_src_data,
  output logic [N_SRC-1:0]            o_src_rdy,
  output logic                        o_snk_vld,
  output logic [DATA_WIDTH-1:0]       o_snk_data,
  input  logic                        i_snk_rdy,
  output logic [N_SRC-1:0]            o_grant,
  output logic                        o_busy
);

  localparam int SW = $clog2(N_SRC);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  arb_state_t            state, state_nxt;
  logic [N_SRC-1:0]      grant, grant_nxt;
  logic [SW-1:0]         gidx, gidx_nxt;
  logic [SW-1:0]         last, last_nxt;
  logic [CW-1:0]         beat_cnt, beat_cnt_nxt;
  logic [1:0]            skid_cnt;
  logic                  cur_vld;
  logic                  accept;
  logic                  pop;
  logic [DATA_WIDTH-1:0] mux_data;
  logic [MAX_SRC-1:0]    pick;
  logic [SW-1:0]         pick_idx;

  assign cur_vld   = |(i_src_vld & grant);
  assign accept    = (state == GRANT) && cur_vld && (skid_cnt != 2'd2);
  assign pop       = o_snk_vld && i_snk_rdy;
  assign o_snk_vld = (skid_cnt != 2'd0);
  assign o_src_rdy = ((state == GRANT) && (skid_cnt != 2'd2)) ? grant : {N_SRC{1'b0}};
  assign o_grant   = grant;
  assign o_busy    = (state == GRANT) || (skid_cnt != 2'd0);

  // Next round-robin candidate and its index.
  always_comb begin
    pick     = rr_pick(MAX_SRC'(i_src_vld), IDX_W'(last), N_SRC);
    pick_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (pick[k]) begin
        pick_idx = SW'(k);
      end else begin
        pick_idx = pick_idx;
      end
    end
  end

  // AND-OR data mux steered by the one-hot grant.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N_SRC; k++) begin
      mux_data = mux_data | (i_src_data[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant[k]}});
    end
  end

  // Arbitration FSM: a dropped valid releases immediately, otherwise the burst limit does.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    gidx_nxt     = gidx;
    last_nxt     = last;
    beat_cnt_nxt = beat_cnt;
    case (state)
      IDLE: begin
        if (|pick) begin
          state_nxt    = GRANT;
          grant_nxt    = pick[N_SRC-1:0];
          gidx_nxt     = pick_idx;
          beat_cnt_nxt = '0;
        end else begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      GRANT: begin
        if (!cur_vld || (accept && (beat_cnt == LAST_BEAT))) begin
          state_nxt    = IDLE;
          grant_nxt    = '0;
          last_nxt     = gidx;
          beat_cnt_nxt = '0;
        end else if (accept) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
        end else begin
          beat_cnt_nxt = beat_cnt;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Arbiter state registers; reset leaves source 0 with first priority.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      gidx     <= '0;
      last     <= SW'(N_SRC - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      gidx     <= gidx_nxt;
      last     <= last_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  avst_skid2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .push  (accept),
    .din   (mux_data),
    .pop   (pop),
    .dout  (o_snk_data),
    .cnt   (skid_cnt)
  );

endmodule

// File: tb/tb_avst_rr_arbiter.sv
// Scoreboard bench for avst_rr_arbiter: one instance with MAX_BURST=16, one with MAX_BURST=4.
module tb_avst_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          sel     = 1'b0;
  logic          snk_rdy = 1'b1;
  logic [N-1:0]  vld     = '0;
  logic [N*DW-1:0] data  = '0;

  logic [N-1:0]  rdy_a, rdy_b, grant_a, grant_b;
  logic          snk_vld_a, snk_vld_b, busy_a, busy_b;
  logic [DW-1:0] snk_data_a, snk_data_b;

  logic [N-1:0]  rdy, grant;
  logic          snk_vld, busy;
  logic [DW-1:0] snk_data;

  assign rdy      = sel ? rdy_b      : rdy_a;
  assign grant    = sel ? grant_b    : grant_a;
  assign snk_vld  = sel ? snk_vld_b  : snk_vld_a;
  assign busy     = sel ? busy_b     : busy_a;
  assign snk_data = sel ? snk_data_b : snk_data_a;

  always #5 clk = ~clk;

  avst_rr_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_src_vld(sel ? {N{1'b0}} : vld), .i_src_data(data), .o_src_rdy(rdy_a),
    .o_snk_vld(snk_vld_a), .o_snk_data(snk_data_a), .i_snk_rdy(snk_rdy),
    .o_grant(grant_a), .o_busy(busy_a)
  );

  avst_rr_arbiter #(.N_SRC(N), .DATA_WIDTH(DW), .MAX_BURST(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_src_vld(sel ? vld : {N{1'b0}}), .i_src_data(data), .o_src_rdy(rdy_b),
    .o_snk_vld(snk_vld_b), .o_snk_data(snk_data_b), .i_snk_rdy(snk_rdy),
    .o_grant(grant_b), .o_busy(busy_b)
  );

  logic [DW-1:0] src_q [N][$];
  logic [DW-1:0] exp_q [$];
  logic [N-1:0]  en = '0;
  logic [N-1:0]  g_smp;
  logic          dn_hs;
  int tests = 0;
  int fails = 0;
  int up_cnt = 0;
  int dn_cnt = 0;
  int hs_src = -1;
  int cyc = 0;

  task automatic drive_src();
    for (int k = 0; k < N; k++) begin
      vld[k] = en[k] && (src_q[k].size() > 0);
      data[k*DW +: DW] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
    end
  endtask

  task automatic clear_all();
    for (int k = 0; k < N; k++) src_q[k].delete();
    exp_q.delete();
    en = '0;
    up_cnt = 0;
    dn_cnt = 0;
    drive_src();
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < N; k++) s += src_q[k].size();
    return s;
  endfunction

  // One clock: sample handshakes at negedge, then update models just after posedge.
  task automatic step();
    logic [N-1:0]  hs;
    logic          d_hs;
    logic [DW-1:0] d_data;
    logic [DW-1:0] e;
    logic          r;
    @(negedge clk);
    hs = vld & rdy;
    d_hs = snk_vld & snk_rdy;
    d_data = snk_data;
    r = rst_n;
    g_smp = grant;
    tests++;
    if ($countones(rdy) > 1) begin
      fails++;
      $display("FAIL rdy_onehot: rdy=%b, required at most one bit set", rdy);
    end
    @(posedge clk);
    #1;
    cyc++;
    dn_hs = d_hs;
    hs_src = -1;
    if (d_hs) begin
      dn_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_underflow: got %h, required no beat", d_data);
      end else begin
        e = exp_q.pop_front();
        if (d_data !== e) begin
          fails++;
          $display("FAIL sb_data: got %h, required %h", d_data, e);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        exp_q.push_back(src_q[k].pop_front());
        hs_src = k;
        up_cnt++;
      end
    end
    if (!r) exp_q.delete();
    drive_src();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    clear_all();
  endtask

  task automatic drain(input int total, input string name);
    int b = 0;
    while ((pending() > 0 || exp_q.size() > 0 || busy === 1'b1) && b < 400) begin
      step();
      b++;
    end
    tests++;
    if (dn_cnt != total || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_count: delivered %0d, required %0d (scoreboard left %0d)",
               name, dn_cnt, total, exp_q.size());
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    clear_all();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 4; i++) src_q[k].push_back(DW'(k * 256 + i));
    en = '1;
    drive_src();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if (rdy !== 4'b0000 || snk_vld !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_outputs: rdy=%b vld=%b grant=%b busy=%b, required all 0",
                 rdy, snk_vld, grant, busy);
      end
    end
    rst_n = 1'b1;
    clear_all();
    step();
  endtask

  task automatic test_single_stream();
    int hc [32];
    int b = 0;
    sel = 1'b0;
    snk_rdy = 1'b1;
    clear_all();
    for (int i = 0; i < 32; i++) src_q[2].push_back(DW'(32'hA0 + i));
    en = 4'b0100;
    drive_src();
    while (up_cnt < 32 && b < 200) begin
      step();
      b++;
      if (hs_src >= 0) begin
        hc[up_cnt-1] = cyc;
        tests++;
        if (hs_src != 2 || g_smp !== 4'b0100) begin
          fails++;
          $display("FAIL t2_grant: src=%0d grant=%b, required src 2 grant 0100", hs_src, g_smp);
        end
      end
    end
    tests++;
    if (up_cnt != 32) begin
      fails++;
      $display("FAIL t2_timeout: accepted %0d, required 32", up_cnt);
    end else begin
      for (int i = 1; i < 32; i++) begin
        tests++;
        if (hc[i] - hc[i-1] != ((i == 16) ? 2 : 1)) begin
          fails++;
          $display("FAIL t2_gap: beat %0d gap %0d, required %0d", i, hc[i] - hc[i-1],
                   (i == 16) ? 2 : 1);
        end
      end
    end
    drain(32, "t2");
  endtask

  task automatic test_round_robin();
    int b = 0;
    int exp_src;
    sel = 1'b1;
    snk_rdy = 1'b1;
    do_reset();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < 8; i++) src_q[k].push_back(DW'(k * 256 + 16 + i));
    en = 4'b1111;
    drive_src();
    while (up_cnt < 32 && b < 300) begin
      step();
      b++;
      if (hs_src >= 0) begin
        exp_src = ((up_cnt - 1) / 4) % 4;
        tests++;
        if (hs_src != exp_src) begin
          fails++;
          $display("FAIL t3_order: beat %0d from src %0d, required src %0d", up_cnt - 1, hs_src, exp_src);
        end
      end
    end
    drain(32, "t3");
    sel = 1'b0;
  endtask

  task automatic test_early_release();
    int seq [7] = '{1, 1, 1, 2, 2, 3, 3};
    int b = 0;
    sel = 1'b0;
    snk_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) src_q[1].push_back(DW'(16'h1100 + i));
    for (int i = 0; i < 2; i++) src_q[2].push_back(DW'(16'h2200 + i));
    for (int i = 0; i < 2; i++) src_q[3].push_back(DW'(16'h3300 + i));
    en = 4'b1111;
    drive_src();
    while (up_cnt < 7 && b < 100) begin
      step();
      b++;
      if (hs_src >= 0) begin
        tests++;
        if (hs_src != seq[up_cnt-1]) begin
          fails++;
          $display("FAIL t4_order: beat %0d from src %0d, required src %0d", up_cnt - 1, hs_src, seq[up_cnt-1]);
        end
      end
    end
    drain(7, "t4");
  endtask

  task automatic test_backpressure();
    int b = 0;
    int n = 0;
    sel = 1'b0;
    snk_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) src_q[0].push_back(DW'(16'h5000 + i));
    en = 4'b0001;
    drive_src();
    while (up_cnt < 5 && b < 30) begin
      step();
      b++;
    end
    snk_rdy = 1'b0;
    repeat (10) step();
    tests++;
    if (rdy !== 4'b0000 || snk_vld !== 1'b1 || grant !== 4'b0001 || up_cnt - dn_cnt != 2) begin
      fails++;
      $display("FAIL t5_stall: rdy=%b vld=%b grant=%b held=%0d, required 0000 1 0001 2",
               rdy, snk_vld, grant, up_cnt - dn_cnt);
    end
    snk_rdy = 1'b1;
    repeat (8) begin
      step();
      if (dn_hs) n++;
    end
    tests++;
    if (n != 8) begin
      fails++;
      $display("FAIL t5_throughput: %0d beats in 8 cycles, required 8", n);
    end
    drain(20, "t5");
  endtask

  task automatic test_reset_mid();
    int b = 0;
    int total;
    sel = 1'b0;
    snk_rdy = 1'b1;
    do_reset();
    for (int i = 0; i < 24; i++) src_q[1].push_back(DW'(16'h6100 + i));
    en = 4'b0010;
    drive_src();
    while (up_cnt < 18 && b < 60) begin
      step();
      b++;
    end
    snk_rdy = 1'b0;
    b = 0;
    while (rdy !== 4'b0000 && b < 10) begin
      step();
      b++;
    end
    tests++;
    if (rdy !== 4'b0000 || snk_vld !== 1'b1) begin
      fails++;
      $display("FAIL t6_full: rdy=%b vld=%b, required 0000 1", rdy, snk_vld);
    end
    rst_n = 1'b0;
    step();
    tests++;
    if (snk_vld !== 1'b0 || grant !== 4'b0000 || rdy !== 4'b0000) begin
      fails++;
      $display("FAIL t6_reset: vld=%b grant=%b rdy=%b, required 0 0000 0000", snk_vld, grant, rdy);
    end
    rst_n = 1'b1;
    up_cnt = 0;
    dn_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      src_q[0].push_back(DW'(16'h7000 + i));
      src_q[2].push_back(DW'(16'h7200 + i));
      src_q[3].push_back(DW'(16'h7300 + i));
    end
    en = 4'b1111;
    snk_rdy = 1'b1;
    drive_src();
    total = pending();
    b = 0;
    while (hs_src < 0 && b < 10) begin
      step();
      b++;
    end
    tests++;
    if (hs_src != 0) begin
      fails++;
      $display("FAIL t6_first: first grant src %0d, required src 0", hs_src);
    end
    drain(total, "t6");
  endtask

  initial begin
    test_reset();
    test_single_stream();
    test_round_robin();
    test_early_release();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
